// File: rtl/iob_spi_fl_prog_seq.sv
// Flash write/erase sequencer: WREN, then PAGE PROGRAM or SECTOR ERASE, then RDSR polling
// until WIP clears or the poll limit is reached. Drives the SPI flash controller request port.
module iob_spi_fl_prog_seq #(
  parameter int MAX_POLLS  = 65535,
  parameter int GAP_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op,
  input  logic [23:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        fl_valid,
  output logic [31:0] fl_address,
  output logic [31:0] fl_command,
  output logic [31:0] fl_commandtp,
  output logic [31:0] fl_datain,
  input  logic        fl_ready,
  input  logic [31:0] fl_dataout
);

  typedef enum logic [3:0] {
    S_IDLE, S_WREN, S_WREN_W, S_OP, S_OP_W, S_POLL, S_POLL_W, S_GAP, S_FIN
  } state_t;

  localparam logic [15:0] POLL_LIMIT = 16'(MAX_POLLS);
  // GAP_CYCLES is the whole idle stretch between polls; the POLL setup cycle is one of them
  localparam logic [15:0] GAP_LAST   = (GAP_CYCLES > 1) ? 16'(GAP_CYCLES - 2) : 16'd0;

  state_t      state_reg, state_next;
  logic        op_reg, op_next;
  logic [15:0] poll_cnt_reg, poll_cnt_next, poll_cnt_inc;
  logic [15:0] gap_cnt_reg, gap_cnt_next;
  logic        busy_next, done_next, err_next, valid_next;
  logic [31:0] address_next, command_next, commandtp_next, datain_next;

  function automatic logic [31:0] make_cmd(input logic [7:0] opcode, input logic [6:0] nbits);
    return {16'h0000, 1'b0, nbits, opcode};
  endfunction

  assign poll_cnt_inc = (poll_cnt_reg == 16'hFFFF) ? poll_cnt_reg : poll_cnt_reg + 16'd1;

  always_comb begin
    state_next     = state_reg;
    op_next        = op_reg;
    poll_cnt_next  = poll_cnt_reg;
    gap_cnt_next   = gap_cnt_reg;
    busy_next      = busy;
    done_next      = 1'b0;
    err_next       = err;
    valid_next     = fl_valid;
    address_next   = fl_address;
    command_next   = fl_command;
    commandtp_next = fl_commandtp;
    datain_next    = fl_datain;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          op_next      = op;
          address_next = {8'h00, addr};
          datain_next  = wdata;
          err_next     = 1'b0;
          busy_next    = 1'b1;
          state_next   = S_WREN;
        end
      end
      S_WREN: begin
        command_next   = make_cmd(8'h06, 7'd0);
        commandtp_next = 32'd0;
        valid_next     = 1'b1;
        state_next     = S_WREN_W;
      end
      S_WREN_W: begin
        if (fl_ready) begin
          valid_next = 1'b0;
          state_next = S_OP;
        end
      end
      S_OP: begin
        if (op_reg) begin
          command_next   = make_cmd(8'h20, 7'd0);
          commandtp_next = 32'd3;
        end else begin
          command_next   = make_cmd(8'h02, 7'd32);
          commandtp_next = 32'd2;
        end
        valid_next = 1'b1;
        state_next = S_OP_W;
      end
      S_OP_W: begin
        if (fl_ready) begin
          valid_next    = 1'b0;
          poll_cnt_next = 16'd0;
          state_next    = S_POLL;
        end
      end
      S_POLL: begin
        command_next   = make_cmd(8'h05, 7'd8);
        commandtp_next = 32'd1;
        valid_next     = 1'b1;
        state_next     = S_POLL_W;
      end
      S_POLL_W: begin
        if (fl_ready) begin
          valid_next    = 1'b0;
          poll_cnt_next = poll_cnt_inc;
          if (!fl_dataout[0] || poll_cnt_inc == POLL_LIMIT) begin
            err_next   = fl_dataout[0];
            done_next  = 1'b1;
            busy_next  = 1'b0;
            state_next = S_FIN;
          end else if (GAP_CYCLES > 1) begin
            gap_cnt_next = 16'd0;
            state_next   = S_GAP;
          end else begin
            state_next = S_POLL;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_reg == GAP_LAST) state_next = S_POLL;
        else gap_cnt_next = gap_cnt_reg + 16'd1;
      end
      S_FIN: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      op_reg       <= 1'b0;
      poll_cnt_reg <= 16'd0;
      gap_cnt_reg  <= 16'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      fl_valid     <= 1'b0;
      fl_address   <= 32'd0;
      fl_command   <= 32'd0;
      fl_commandtp <= 32'd0;
      fl_datain    <= 32'd0;
    end else begin
      state_reg    <= state_next;
      op_reg       <= op_next;
      poll_cnt_reg <= poll_cnt_next;
      gap_cnt_reg  <= gap_cnt_next;
      busy         <= busy_next;
      done         <= done_next;
      err          <= err_next;
      fl_valid     <= valid_next;
      fl_address   <= address_next;
      fl_command   <= command_next;
      fl_commandtp <= commandtp_next;
      fl_datain    <= datain_next;
    end
  end

endmodule
